regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 4 x 8-bit register file among NUM_REQ requesters (execute, load return, debug) using round-robin arbitration with a valid/ready handshake.
- Drives the register file's write_enable, write_addr and write_data from a registered output stage.
- Exports per-register pending bits so read-side logic can stall on read-after-write hazards.

---
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ
// requesters, with a registered write stage and per-register pending bits for hazard stalls.
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 2 ** ADDR_W,
    parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rf_write_enable,
    output logic [ADDR_W-1:0]          rf_write_addr,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic [NUM_REGS-1:0]        reg_pending,
    output logic [IDX_W-1:0]           last_grant,
    output logic [7:0]                 write_count
);

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        count_q, count_d;

    logic              found_hi, found_lo, transfer;
    logic [IDX_W-1:0]  idx_hi, idx_lo, grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Winner is the lowest valid index at or above ptr, else the lowest valid index overall.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(i);
                if (IDX_W'(i) >= ptr_q) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        transfer  = found_lo && !stall;
    end

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                req_ready[i] = transfer;
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = transfer;
        count_d      = we_q ? count_q + 8'd1 : count_q;
        if (transfer) begin
            addr_d       = sel_addr;
            data_d       = sel_data;
            last_grant_d = grant_idx;
            ptr_d        = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // A register is pending while any requester targets it or the output stage is writing it.
    always_comb begin
        reg_pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (we_q && addr_q == ADDR_W'(r))
                reg_pending[r] = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    reg_pending[r] = 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            last_grant_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            count_q      <= '0;
        end else begin
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            count_q      <= count_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = addr_q;
    assign rf_write_data   = data_q;
    assign last_grant      = last_grant_q;
    assign write_count     = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle-level reference model predicts every
// write, and a negedge monitor compares outputs and pops expected writes as they appear.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int IDX_W    = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      stall = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_write_enable;
    logic [ADDR_W-1:0]         rf_write_addr;
    logic [DATA_W-1:0]         rf_write_data;
    logic [NUM_REGS-1:0]       reg_pending;
    logic [IDX_W-1:0]          last_grant;
    logic [7:0]                write_count;

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .reg_pending(reg_pending),
        .last_grant(last_grant), .write_count(write_count)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT write port.
    logic [DATA_W-1:0] tb_rf [NUM_REGS];
    always @(posedge clk) if (rf_write_enable) tb_rf[rf_write_addr] <= rf_write_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                idx;
    } exp_t;

    exp_t              exp_q[$];
    int                m_ptr   = 0;
    int                m_count = 0;
    logic              m_we    = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;

    function automatic int model_winner(logic [NUM_REQ-1:0] v, int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (ptr + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_ready();
        logic [NUM_REQ-1:0] r;
        int w;
        r = '0;
        w = model_winner(req_valid, m_ptr);
        if (w >= 0 && !stall) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [NUM_REGS-1:0] exp_pending();
        logic [NUM_REGS-1:0] p;
        p = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (m_we && int'(m_addr) == r) p[r] = 1'b1;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && int'(req_addr[i*ADDR_W +: ADDR_W]) == r) p[r] = 1'b1;
        end
        return p;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_ptr   = 0;
            m_count = 0;
            m_we    = 1'b0;
            m_addr  = '0;
            exp_q.delete();
        end else begin
            int w;
            exp_t e;
            if (m_we) m_count = (m_count + 1) % 256;
            w = model_winner(req_valid, m_ptr);
            if (w >= 0 && !stall) begin
                e.addr = req_addr[w*ADDR_W +: ADDR_W];
                e.data = req_data[w*DATA_W +: DATA_W];
                e.idx  = w;
                exp_q.push_back(e);
                m_we   = 1'b1;
                m_addr = e.addr;
                m_ptr  = (w + 1) % NUM_REQ;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        check("req_ready", req_ready, exp_ready());
        check("reg_pending", reg_pending, exp_pending());
        check("rf_write_enable", rf_write_enable, m_we);
        check("write_count", write_count, m_count);
        if (rf_write_enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rf_write_addr", rf_write_addr, e.addr);
                check("rf_write_data", rf_write_data, e.data);
                check("last_grant", last_grant, e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    logic [NUM_REQ-1:0] last_fired = '0;

    task automatic cycle();
        logic [NUM_REQ-1:0] fired;
        @(negedge clk);
        fired = req_valid & req_ready;
        @(posedge clk);
        if (reset) fired = '0;
        #1;
        req_valid  = req_valid & ~fired;
        last_fired = fired;
    endtask

    task automatic set_req(input int i, input int addr, input int data);
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        req_data[i*DATA_W +: DATA_W] = DATA_W'(data);
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (req_valid != '0 && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_done"}, req_valid, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        int fires [NUM_REQ];
        int done;
        int n;

        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        check("reset_we", rf_write_enable, 0);
        check("reset_count", write_count, 0);
        check("reset_last_grant", last_grant, 0);

        // Single request from requester 1.
        set_req(1, 2, 'hA5);
        #1;
        check("t1_ready", req_ready, 3'b010);
        check("t1_pending", reg_pending, 4'b0100);
        cycle();
        check("t1_we", rf_write_enable, 1);
        check("t1_addr", rf_write_addr, 2);
        check("t1_data", rf_write_data, 'hA5);
        check("t1_last_grant", last_grant, 1);
        check("t1_pending_inflight", reg_pending, 4'b0100);
        cycle();
        check("t1_we_off", rf_write_enable, 0);
        check("t1_count", write_count, 1);
        check("t1_pending_clear", reg_pending, 4'b0000);

        // All requesters continuously valid, each served twice.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            fires[i] = 0;
            set_req(i, i, $urandom_range(255, 0));
        end
        n = 0;
        while (req_valid != '0 && n < 20) begin
            cycle();
            n++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_fired[i]) begin
                    fires[i]++;
                    if (fires[i] < 2) set_req(i, i, $urandom_range(255, 0));
                end
            end
        end
        repeat (2) cycle();
        check("t2_count", write_count, 6);

        // Same-address writes with ptr at 2: requester 2 first, requester 0 last.
        set_req(1, 0, 'h55);
        wait_done("t3_setup", 10);
        set_req(0, 3, 'h11);
        set_req(2, 3, 'h22);
        wait_done("t3", 10);
        repeat (2) cycle();
        check("t3_rf3", tb_rf[3], 'h11);

        // Stall holds off grants while pending stays visible.
        stall = 1'b1;
        set_req(0, 1, 'h3C);
        repeat (3) begin
            #1;
            check("t4_ready_stalled", req_ready, 0);
            check("t4_pending", reg_pending[1], 1);
            cycle();
        end
        stall = 1'b0;
        #1;
        check("t4_ready_release", req_ready, 3'b001);
        wait_done("t4", 10);

        // Asynchronous reset while a write is in flight.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 'h40 + i);
        cycle();
        check("t5_we_before", rf_write_enable, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_we_async", rf_write_enable, 0);
        check("t5_count_async", write_count, 0);
        cycle();
        #2 reset = 1'b0;
        #1;
        check("t5_ready_lowest", req_ready, 3'b001);
        wait_done("t5", 10);

        // 260 back-to-back writes from one requester wrap write_count to 4.
        do_reset();
        set_req(0, $urandom_range(3, 0), $urandom_range(255, 0));
        done = 0;
        n = 0;
        while (done < 260 && n < 400) begin
            cycle();
            n++;
            if (last_fired[0]) begin
                done++;
                if (done < 260) set_req(0, $urandom_range(3, 0), $urandom_range(255, 0));
            end
        end
        check("t6_writes", done, 260);
        repeat (2) cycle();
        check("t6_count_wrap", write_count, 4);

        // Randomized traffic with occasional stalls.
        for (int c = 0; c < 400; c++) begin
            cycle();
            stall = ($urandom_range(7, 0) == 0);
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i] && $urandom_range(1, 0) == 1)
                    set_req(i, $urandom_range(3, 0), $urandom_range(255, 0));
        end
        stall = 1'b0;
        wait_done("random_drain", 50);
        repeat (2) cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
